spi_slave_regif: RTL

SPI responder (slave) with a CPU register interface, the counterpart of the SPI master in the soc_system fabric. It lets a Nios/HPS-side register port exchange fixed-width words with an external SPI master. The bus runs mode 0 (CPOL=0, CPHA=0), MSB first by default. SCLK, SS_n and MOSI are oversampled in the clk domain; the block sits on the same 3-bit-address register bus as the master.

---
 rtl/spi_slave_regif.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regif.sv
// -----------------------------------------------------------------------------
// spi_slave_regif
//
// SPI responder (mode 0: CPOL=0, CPHA=0) with a small CPU register port. An
// external SPI master exchanges fixed-width words with the CPU side. SCLK, SS_n
// and MOSI are oversampled in the clk domain through SYNC_STAGES flops followed
// by one history flop used for edge detection.
//
// Build option:
//   SPI_SLAVE_LSBFIRST_EN  defined   -> LSB-first in both directions
//                          undefined -> MSB-first (default)
//
// Parameters:
//   DATABITS     word width, 8..32
//   SYNC_STAGES  synchronizer depth for SCLK/SS_n/MOSI, 2..3
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   spi_select          register-port chip select
//   mem_addr[2:0]       register address (0 rxdata, 1 txdata, 2 status, 3 control)
//   read_n, write_n     active-low access requests
//   data_from_cpu[31:0] write data
//   data_to_cpu[31:0]   registered read data
//   irq                 registered interrupt, OR of enabled status bits
//   SCLK, SS_n, MOSI    SPI inputs from the master
//   MISO, MISO_oe       SPI output and its drive enable
//
// Status bits: [3] ROE, [4] TOE, [5] TUR, [6] TRDY, [7] RRDY, [8] E.
// Control bits [8:3] enable the interrupt for the same positions.
// -----------------------------------------------------------------------------
module spi_slave_regif #(
  parameter int DATABITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] data_from_cpu,
  output logic [31:0] data_to_cpu,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam int CNT_W = $clog2(DATABITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, ss_hist_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Register-port access strobes
  logic        req_d, req_q;
  logic        stb, rd_stb, wr_stb;
  logic [31:0] rd_mux;
  logic [31:0] status_w;
  logic [31:0] dout_d, dout_q;
  logic        irq_d, irq_q;

  // Shift engine
  logic [DATABITS-1:0] shift_d, shift_q;
  logic [DATABITS-1:0] shifted, rx_word;
  logic [CNT_W-1:0]    bitcnt_d, bitcnt_q, bitcnt_inc;
  logic                reload_d, reload_q;
  logic                mosi_bit_d, mosi_bit_q;
  logic                do_load, do_sample, do_shift, word_done;

  // Holding registers and flags
  logic [DATABITS-1:0] rx_d, rx_q;
  logic [DATABITS-1:0] hold_d, hold_q;
  logic                primed_d, primed_q;
  logic                rrdy_d, rrdy_q;
  logic                roe_d, roe_q;
  logic                toe_d, toe_q;
  logic                tur_d, tur_q;
  logic [5:0]          ctrl_d, ctrl_q;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;

  // A request is acted on only in its first cycle; it rearms after an idle cycle.
  assign req_d  = spi_select & (~read_n | ~write_n);
  assign stb    = req_d & ~req_q;
  assign rd_stb = stb & ~read_n;
  assign wr_stb = stb & ~write_n;

  // The MOSI bit taken on the rising edge is only merged into the shift
  // register on the following falling edge, so the bit still being driven
  // out is not overwritten. The completed word merges the live sample.
`ifdef SPI_SLAVE_LSBFIRST_EN
  assign shifted = {mosi_bit_q, shift_q[DATABITS-1:1]};
  assign rx_word = {mosi_s, shift_q[DATABITS-1:1]};
  assign MISO    = shift_q[0];
`else
  assign shifted = {shift_q[DATABITS-2:0], mosi_bit_q};
  assign rx_word = {shift_q[DATABITS-2:0], mosi_s};
  assign MISO    = shift_q[DATABITS-1];
`endif

  assign MISO_oe     = ~ss_s;
  assign data_to_cpu = dout_q;
  assign irq         = irq_q;

  assign bitcnt_inc = bitcnt_q + 1'b1;

  // A deselect overrides every shift-engine action in the same cycle.
  assign do_load   = ~ss_rise & ((state_q == LOAD) |
                                 ((state_q == SHIFT) & sclk_fall & reload_q));
  assign do_sample = ~ss_rise & (state_q == SHIFT) & sclk_rise;
  assign do_shift  = ~ss_rise & (state_q == SHIFT) & sclk_fall & ~reload_q;
  assign word_done = do_sample & (bitcnt_inc == CNT_W'(DATABITS));

  always_comb begin
    status_w    = '0;
    status_w[3] = roe_q;
    status_w[4] = toe_q;
    status_w[5] = tur_q;
    status_w[6] = ~primed_q;
    status_w[7] = rrdy_q;
    status_w[8] = roe_q | toe_q | tur_q;
  end

  always_comb begin
    case (mem_addr)
      3'd0:    rd_mux = 32'(rx_q);
      3'd2:    rd_mux = status_w;
      3'd3:    rd_mux = 32'({ctrl_q, 3'b000});
      default: rd_mux = '0;
    endcase
  end

  assign irq_d = |(status_w[8:3] & ctrl_q);

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = LOAD;
        LOAD:    state_d = SHIFT;
        SHIFT:   state_d = SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and flag next state. CPU-side clears come first so that SPI-side
  // sets in the same cycle take priority.
  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    reload_d   = reload_q;
    mosi_bit_d = mosi_bit_q;
    rx_d       = rx_q;
    hold_d     = hold_q;
    primed_d   = primed_q;
    rrdy_d     = rrdy_q;
    roe_d      = roe_q;
    toe_d      = toe_q;
    tur_d      = tur_q;
    ctrl_d     = ctrl_q;
    dout_d     = dout_q;

    if (rd_stb) begin
      dout_d = rd_mux;
      if (mem_addr == 3'd0) rrdy_d = 1'b0;
    end

    if (wr_stb) begin
      case (mem_addr)
        3'd1: begin
          if (primed_q) begin
            toe_d = 1'b1;
          end else begin
            hold_d   = data_from_cpu[DATABITS-1:0];
            primed_d = 1'b1;
          end
        end
        3'd2: begin
          roe_d  = 1'b0;
          toe_d  = 1'b0;
          tur_d  = 1'b0;
          rrdy_d = 1'b0;
        end
        3'd3:    ctrl_d = data_from_cpu[8:3];
        default: ;
      endcase
    end

    // Deselect drops any partial word; RRDY is left alone.
    if (ss_rise) begin
      bitcnt_d = '0;
      reload_d = 1'b0;
    end

    if (do_load) begin
      if (primed_q) begin
        shift_d  = hold_q;
        primed_d = 1'b0;
      end else begin
        shift_d = '0;
        tur_d   = 1'b1;
      end
      bitcnt_d = '0;
      reload_d = 1'b0;
    end

    if (do_sample) begin
      mosi_bit_d = mosi_s;
      bitcnt_d   = bitcnt_inc;
      if (word_done) begin
        rx_d     = rx_word;
        rrdy_d   = 1'b1;
        reload_d = 1'b1;
        if (rrdy_q) roe_d = 1'b1;
      end
    end

    if (do_shift) shift_d = shifted;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
      state_q     <= IDLE;
      req_q       <= 1'b0;
      irq_q       <= 1'b0;
      dout_q      <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      reload_q    <= 1'b0;
      mosi_bit_q  <= 1'b0;
      rx_q        <= '0;
      hold_q      <= '0;
      primed_q    <= 1'b0;
      rrdy_q      <= 1'b0;
      roe_q       <= 1'b0;
      toe_q       <= 1'b0;
      tur_q       <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
      state_q     <= state_d;
      req_q       <= req_d;
      irq_q       <= irq_d;
      dout_q      <= dout_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      reload_q    <= reload_d;
      mosi_bit_q  <= mosi_bit_d;
      rx_q        <= rx_d;
      hold_q      <= hold_d;
      primed_q    <= primed_d;
      rrdy_q      <= rrdy_d;
      roe_q       <= roe_d;
      toe_q       <= toe_d;
      tur_q       <= tur_d;
      ctrl_q      <= ctrl_d;
    end
  end

endmodule
